// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: address width, default
// geometry and the refill controller state encoding.
package icache_pkg;

   localparam int ADDR_WIDTH    = 32;
   localparam int DEFAULT_LINES = 16;

   // IDLE serves lookups; FETCH waits for the backing memory to return a word.
   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } cacheState_t;

endpackage

// File: rtl/icache_line_store.sv
// Direct-mapped line storage: per-line valid bit, tag and one data word.
// One synchronous write port, one combinational read port and a bulk
// invalidate. Only the valid bits are reset; tag/data contents are don't-care
// until their line is validated.
module icache_line_store
   import icache_pkg::*;
#(
   parameter int LINES       = DEFAULT_LINES,
   parameter int INDEX_WIDTH = $clog2(LINES),
   parameter int TAG_WIDTH   = ADDR_WIDTH - 2 - INDEX_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clearAll,
   input  logic                   writeEnable,
   input  logic [INDEX_WIDTH-1:0] writeIndex,
   input  logic [TAG_WIDTH-1:0]   writeTag,
   input  logic [31:0]            writeData,
   input  logic [INDEX_WIDTH-1:0] readIndex,
   output logic                   readValid,
   output logic [TAG_WIDTH-1:0]   readTag,
   output logic [31:0]            readData
);

   logic [TAG_WIDTH-1:0] tagMem [LINES];
   logic [31:0]          dataMem [LINES];
   logic [LINES-1:0]     validBits;

   // Tag and data arrays are written on a fill; no reset so they map to RAM.
   always_ff @(posedge clk) begin
      if (writeEnable) begin
         tagMem[writeIndex]  <= writeTag;
         dataMem[writeIndex] <= writeData;
      end
   end

   generate
      for (genvar gi = 0; gi < LINES; gi++) begin : gLine
         logic lineValidReg;

         // Invalidate wins over a simultaneous fill so a flush always leaves
         // every line empty.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               lineValidReg <= 1'b0;
            end else if (clearAll) begin
               lineValidReg <= 1'b0;
            end else if (writeEnable && (writeIndex == INDEX_WIDTH'(gi))) begin
               lineValidReg <= 1'b1;
            end
         end

         assign validBits[gi] = lineValidReg;
      end
   endgenerate

   assign readValid = validBits[readIndex];
   assign readTag   = tagMem[readIndex];
   assign readData  = dataMem[readIndex];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache with single-word lines.
// Hits are answered combinationally in the same cycle; a miss starts a
// one-word refill from backing memory and the core stalls until it lands.
// Optional hit/miss statistics are built when ICACHE_STATS_EN is defined.
module instruction_cache
   import icache_pkg::*;
#(
   parameter int LINES = DEFAULT_LINES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] cpuAddress,
   output logic [31:0]           cpuInstruction,
   output logic                  cpuSuccess,
   input  logic                  flush,
   output logic                  memRequest,
   output logic [ADDR_WIDTH-1:0] memAddress,
   input  logic                  memReady,
   input  logic [31:0]           memData
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0]           hitCount,
   output logic [31:0]           missCount
`endif
);

   localparam int INDEX_WIDTH = $clog2(LINES);
   localparam int TAG_WIDTH   = ADDR_WIDTH - 2 - INDEX_WIDTH;

   cacheState_t stateReg, stateNext;

   // Word address of the line being refilled; memAddress is this plus 2'b00.
   logic [ADDR_WIDTH-3:0] fillWordReg;

   logic [INDEX_WIDTH-1:0] cpuIndex;
   logic [TAG_WIDTH-1:0]   cpuTag;
   logic                   readValid;
   logic [TAG_WIDTH-1:0]   readTag;
   logic [31:0]            readData;
   logic                   lookupHit;
   logic                   captureAddress;
   logic                   fillEnable;
   logic                   unusedBits;

   assign cpuIndex = cpuAddress[INDEX_WIDTH+1:2];
   assign cpuTag   = cpuAddress[ADDR_WIDTH-1:INDEX_WIDTH+2];

   // Bit 0 is meaningless for halfword-aligned fetches.
   assign unusedBits = cpuAddress[0];

   icache_line_store #(
      .LINES       (LINES),
      .INDEX_WIDTH (INDEX_WIDTH),
      .TAG_WIDTH   (TAG_WIDTH)
   ) lineStore (
      .clk         (clk),
      .rst         (rst),
      .clearAll    (flush),
      .writeEnable (fillEnable),
      .writeIndex  (fillWordReg[INDEX_WIDTH-1:0]),
      .writeTag    (fillWordReg[ADDR_WIDTH-3:INDEX_WIDTH]),
      .writeData   (memData),
      .readIndex   (cpuIndex),
      .readValid   (readValid),
      .readTag     (readTag),
      .readData    (readData)
   );

   // A lookup only counts in IDLE; a flush cycle never reports a hit.
   assign lookupHit  = (stateReg == IDLE) && readValid && (readTag == cpuTag);
   assign cpuSuccess = lookupHit && !flush;

   // Upper halfword of the word is returned for addresses with bit 1 set
   // (compressed instruction); the bus is zeroed whenever the core stalls.
   assign cpuInstruction = !cpuSuccess ? 32'h0 :
                           cpuAddress[1] ? {16'h0000, readData[31:16]} : readData;

   assign memRequest = (stateReg == FETCH);
   assign memAddress = {fillWordReg, 2'b00};

   // State register; reset drops memRequest immediately since it decodes state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateReg <= IDLE;
      end else begin
         stateReg <= stateNext;
      end
   end

   // Next state, refill-address capture and fill strobe.
   always_comb begin
      stateNext      = stateReg;
      captureAddress = 1'b0;
      fillEnable     = 1'b0;
      case (stateReg)
         IDLE: begin
            if (!flush && !lookupHit) begin
               stateNext      = FETCH;
               captureAddress = 1'b1;
            end
         end
         FETCH: begin
            if (flush) begin
               stateNext = IDLE;
            end else if (memReady) begin
               stateNext  = IDLE;
               fillEnable = 1'b1;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // Latch the missing word address; it holds for the whole refill even if
   // the core moves cpuAddress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fillWordReg <= '0;
      end else if (captureAddress) begin
         fillWordReg <= cpuAddress[ADDR_WIDTH-1:2];
      end
   end

`ifdef ICACHE_STATS_EN
   logic [31:0] hitCountReg;
   logic [31:0] missCountReg;

   // Hits counted per successful cycle, misses per refill launched; both wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hitCountReg  <= '0;
         missCountReg <= '0;
      end else begin
         if (cpuSuccess) begin
            hitCountReg <= hitCountReg + 32'd1;
         end
         if (captureAddress) begin
            missCountReg <= missCountReg + 32'd1;
         end
      end
   end

   assign hitCount  = hitCountReg;
   assign missCount = missCountReg;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Directed testbench for instruction_cache (LINES=16). Inputs are driven at
// the falling edge and outputs sampled 1 ns later, away from the rising edge.
module tb_instruction_cache;

   logic        clk;
   logic        rst;
   logic [31:0] cpuAddress;
   logic [31:0] cpuInstruction;
   logic        cpuSuccess;
   logic        flush;
   logic        memRequest;
   logic [31:0] memAddress;
   logic        memReady;
   logic [31:0] memData;
`ifdef ICACHE_STATS_EN
   logic [31:0] hitCount;
   logic [31:0] missCount;
`endif

   int assertCount = 0;
   int failCount   = 0;

   instruction_cache #(.LINES(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .cpuAddress     (cpuAddress),
      .cpuInstruction (cpuInstruction),
      .cpuSuccess     (cpuSuccess),
      .flush          (flush),
      .memRequest     (memRequest),
      .memAddress     (memAddress),
      .memReady       (memReady),
      .memData        (memData)
`ifdef ICACHE_STATS_EN
      ,
      .hitCount       (hitCount),
      .missCount      (missCount)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Miss at addr (must currently miss in IDLE), one FETCH cycle, then memReady.
   // Returns in the low phase of the first IDLE cycle after the fill.
   task automatic doFill(input logic [31:0] addr, input logic [31:0] data);
      cpuAddress = addr;
      @(negedge clk);
      memReady = 1'b1;
      memData  = data;
      @(negedge clk);
      memReady = 1'b0;
      memData  = 32'h0;
      #1;
   endtask

   task automatic test_reset();
      #1;
      assertCount++; if (memRequest !== 1'b0) begin failCount++; $display("FAIL reset_memRequest: got %b expected 0", memRequest); end
      assertCount++; if (memAddress !== 32'h0) begin failCount++; $display("FAIL reset_memAddress: got %h expected 00000000", memAddress); end
      assertCount++; if (cpuSuccess !== 1'b0) begin failCount++; $display("FAIL reset_cpuSuccess: got %b expected 0", cpuSuccess); end
      assertCount++; if (cpuInstruction !== 32'h0) begin failCount++; $display("FAIL reset_cpuInstruction: got %h expected 00000000", cpuInstruction); end
`ifdef ICACHE_STATS_EN
      assertCount++; if (hitCount !== 32'h0) begin failCount++; $display("FAIL reset_hitCount: got %0d expected 0", hitCount); end
      assertCount++; if (missCount !== 32'h0) begin failCount++; $display("FAIL reset_missCount: got %0d expected 0", missCount); end
`endif
      @(negedge clk);
      rst = 1'b0;
      cpuAddress = 32'h0;
      #1;
      assertCount++; if (cpuSuccess !== 1'b0) begin failCount++; $display("FAIL first_fetch_miss: got %b expected 0", cpuSuccess); end
      @(negedge clk);
      #1;
      assertCount++; if (memRequest !== 1'b1) begin failCount++; $display("FAIL first_memRequest: got %b expected 1", memRequest); end
      assertCount++; if (memAddress !== 32'h0) begin failCount++; $display("FAIL first_memAddress: got %h expected 00000000", memAddress); end
      // Abandon this refill with a short reset pulse in the low phase.
      rst = 1'b1;
      #1;
      rst = 1'b0;
      #1;
      $display("test_reset done");
   endtask

   task automatic test_miss_fill();
      cpuAddress = 32'h40;
      #1;
      assertCount++; if (cpuSuccess !== 1'b0) begin failCount++; $display("FAIL miss40_success: got %b expected 0", cpuSuccess); end
      assertCount++; if (cpuInstruction !== 32'h0) begin failCount++; $display("FAIL miss40_instr_zero: got %h expected 00000000", cpuInstruction); end
      @(negedge clk); #1;
      assertCount++; if (memRequest !== 1'b1) begin failCount++; $display("FAIL miss40_memRequest: got %b expected 1", memRequest); end
      assertCount++; if (memAddress !== 32'h40) begin failCount++; $display("FAIL miss40_memAddress: got %h expected 00000040", memAddress); end
      @(negedge clk); #1;
      assertCount++; if (memRequest !== 1'b1) begin failCount++; $display("FAIL miss40_memRequest_hold: got %b expected 1", memRequest); end
      assertCount++; if (cpuSuccess !== 1'b0) begin failCount++; $display("FAIL miss40_stall: got %b expected 0", cpuSuccess); end
      @(negedge clk);
      memReady = 1'b1;
      memData  = 32'h00500093;
      #1;
      assertCount++; if (cpuSuccess !== 1'b0) begin failCount++; $display("FAIL miss40_ready_cycle: got %b expected 0", cpuSuccess); end
      @(negedge clk);
      memReady = 1'b0;
      memData  = 32'h0;
      #1;
      assertCount++; if (cpuSuccess !== 1'b1) begin failCount++; $display("FAIL hit40_success: got %b expected 1", cpuSuccess); end
      assertCount++; if (cpuInstruction !== 32'h00500093) begin failCount++; $display("FAIL hit40_instr: got %h expected 00500093", cpuInstruction); end
      assertCount++; if (memRequest !== 1'b0) begin failCount++; $display("FAIL hit40_memRequest: got %b expected 0", memRequest); end
`ifdef ICACHE_STATS_EN
      assertCount++; if (missCount !== 32'd1) begin failCount++; $display("FAIL miss40_missCount: got %0d expected 1", missCount); end
      assertCount++; if (hitCount !== 32'd0) begin failCount++; $display("FAIL miss40_hitCount: got %0d expected 0", hitCount); end
      @(negedge clk); #1;
      assertCount++; if (hitCount !== 32'd1) begin failCount++; $display("FAIL hit40_hitCount: got %0d expected 1", hitCount); end
`endif
      $display("test_miss_fill done");
   endtask

   task automatic test_flush_idle();
      cpuAddress = 32'h40;
      flush = 1'b1;
      #1;
      assertCount++; if (cpuSuccess !== 1'b0) begin failCount++; $display("FAIL flush_cycle_success: got %b expected 0", cpuSuccess); end
      assertCount++; if (cpuInstruction !== 32'h0) begin failCount++; $display("FAIL flush_cycle_instr: got %h expected 00000000", cpuInstruction); end
      @(negedge clk);
      flush = 1'b0;
      #1;
      assertCount++; if (cpuSuccess !== 1'b0) begin failCount++; $display("FAIL after_flush_miss: got %b expected 0", cpuSuccess); end
      assertCount++; if (memRequest !== 1'b0) begin failCount++; $display("FAIL after_flush_memRequest: got %b expected 0", memRequest); end
      $display("test_flush_idle done");
   endtask

   task automatic test_halfword();
      doFill(32'h40, 32'h12344501);
      assertCount++; if (cpuInstruction !== 32'h12344501) begin failCount++; $display("FAIL word40_instr: got %h expected 12344501", cpuInstruction); end
      cpuAddress = 32'h42;
      #1;
      assertCount++; if (cpuSuccess !== 1'b1) begin failCount++; $display("FAIL half42_success: got %b expected 1", cpuSuccess); end
      assertCount++; if (cpuInstruction !== 32'h00001234) begin failCount++; $display("FAIL half42_instr: got %h expected 00001234", cpuInstruction); end
      $display("test_halfword done");
   endtask

   task automatic test_conflict();
      cpuAddress = 32'h00;
      #1;
      assertCount++; if (cpuSuccess !== 1'b0) begin failCount++; $display("FAIL conflict_00_first_miss: got %b expected 0", cpuSuccess); end
      doFill(32'h00, 32'hAAAA0001);
      assertCount++; if (cpuInstruction !== 32'hAAAA0001) begin failCount++; $display("FAIL conflict_00_hit: got %h expected aaaa0001", cpuInstruction); end
      cpuAddress = 32'h40;
      #1;
      assertCount++; if (cpuSuccess !== 1'b0) begin failCount++; $display("FAIL conflict_40_evicted: got %b expected 0", cpuSuccess); end
      doFill(32'h40, 32'h12344501);
      cpuAddress = 32'h00;
      #1;
      assertCount++; if (cpuSuccess !== 1'b0) begin failCount++; $display("FAIL conflict_00_evicted: got %b expected 0", cpuSuccess); end
      doFill(32'h00, 32'hAAAA0001);
      assertCount++; if (cpuSuccess !== 1'b1) begin failCount++; $display("FAIL conflict_00_refill: got %b expected 1", cpuSuccess); end
      $display("test_conflict done");
   endtask

   task automatic test_flush_fill();
      cpuAddress = 32'h84;
      #1;
      assertCount++; if (cpuSuccess !== 1'b0) begin failCount++; $display("FAIL flushfill_84_miss: got %b expected 0", cpuSuccess); end
      @(negedge clk);
      memReady = 1'b1;
      memData  = 32'h55556666;
      flush    = 1'b1;
      #1;
      assertCount++; if (memAddress !== 32'h84) begin failCount++; $display("FAIL flushfill_memAddress: got %h expected 00000084", memAddress); end
      @(negedge clk);
      memReady = 1'b0;
      memData  = 32'h0;
      flush    = 1'b0;
      #1;
      assertCount++; if (cpuSuccess !== 1'b0) begin failCount++; $display("FAIL flushfill_discarded: got %b expected 0", cpuSuccess); end
      assertCount++; if (memRequest !== 1'b0) begin failCount++; $display("FAIL flushfill_idle: got %b expected 0", memRequest); end
      cpuAddress = 32'h00;
      #1;
      assertCount++; if (cpuSuccess !== 1'b0) begin failCount++; $display("FAIL flushfill_all_cleared: got %b expected 0", cpuSuccess); end
      doFill(32'h84, 32'h55556666);
      assertCount++; if (cpuInstruction !== 32'h55556666) begin failCount++; $display("FAIL flushfill_refetch: got %h expected 55556666", cpuInstruction); end
      $display("test_flush_fill done");
   endtask

   task automatic test_addr_change();
      cpuAddress = 32'h8C;
      @(negedge clk);
      cpuAddress = 32'h04;
      #1;
      assertCount++; if (memAddress !== 32'h8C) begin failCount++; $display("FAIL addrchg_memAddress: got %h expected 0000008c", memAddress); end
      assertCount++; if (memRequest !== 1'b1) begin failCount++; $display("FAIL addrchg_memRequest: got %b expected 1", memRequest); end
      assertCount++; if (cpuSuccess !== 1'b0) begin failCount++; $display("FAIL addrchg_stall: got %b expected 0", cpuSuccess); end
      @(negedge clk);
      memReady = 1'b1;
      memData  = 32'h11112222;
      #1;
      assertCount++; if (memAddress !== 32'h8C) begin failCount++; $display("FAIL addrchg_memAddress_ready: got %h expected 0000008c", memAddress); end
      @(negedge clk);
      memReady = 1'b0;
      memData  = 32'h0;
      #1;
      assertCount++; if (cpuSuccess !== 1'b0) begin failCount++; $display("FAIL addrchg_04_miss: got %b expected 0", cpuSuccess); end
      cpuAddress = 32'h8C;
      #1;
      assertCount++; if (cpuInstruction !== 32'h11112222) begin failCount++; $display("FAIL addrchg_8c_hit: got %h expected 11112222", cpuInstruction); end
      cpuAddress = 32'h8E;
      #1;
      assertCount++; if (cpuInstruction !== 32'h00001111) begin failCount++; $display("FAIL addrchg_8e_half: got %h expected 00001111", cpuInstruction); end
      $display("test_addr_change done");
   endtask

   task automatic test_reset_fetch();
      cpuAddress = 32'h88;
      @(negedge clk);
      #1;
      assertCount++; if (memRequest !== 1'b1) begin failCount++; $display("FAIL rstfetch_memRequest: got %b expected 1", memRequest); end
      assertCount++; if (memAddress !== 32'h88) begin failCount++; $display("FAIL rstfetch_memAddress: got %h expected 00000088", memAddress); end
      rst = 1'b1;
      #1;
      assertCount++; if (memRequest !== 1'b0) begin failCount++; $display("FAIL rstfetch_async_drop: got %b expected 0", memRequest); end
      assertCount++; if (memAddress !== 32'h0) begin failCount++; $display("FAIL rstfetch_async_addr: got %h expected 00000000", memAddress); end
`ifdef ICACHE_STATS_EN
      assertCount++; if (hitCount !== 32'h0) begin failCount++; $display("FAIL rstfetch_hitCount: got %0d expected 0", hitCount); end
      assertCount++; if (missCount !== 32'h0) begin failCount++; $display("FAIL rstfetch_missCount: got %0d expected 0", missCount); end
`endif
      @(negedge clk);
      rst      = 1'b0;
      flush    = 1'b1;
      memReady = 1'b1;
      memData  = 32'hDEADBEEF;
      @(negedge clk);
      flush    = 1'b0;
      memReady = 1'b0;
      memData  = 32'h0;
      #1;
      assertCount++; if (cpuSuccess !== 1'b0) begin failCount++; $display("FAIL rstfetch_late_ready_ignored: got %b expected 0", cpuSuccess); end
      assertCount++; if (memRequest !== 1'b0) begin failCount++; $display("FAIL rstfetch_idle: got %b expected 0", memRequest); end
      cpuAddress = 32'h8C;
      #1;
      assertCount++; if (cpuSuccess !== 1'b0) begin failCount++; $display("FAIL rstfetch_valid_cleared: got %b expected 0", cpuSuccess); end
`ifdef ICACHE_STATS_EN
      assertCount++; if (missCount !== 32'h0) begin failCount++; $display("FAIL rstfetch_missCount_after: got %0d expected 0", missCount); end
`endif
      rst = 1'b1;
      $display("test_reset_fetch done");
   endtask

   initial begin
      rst        = 1'b1;
      cpuAddress = 32'h0;
      flush      = 1'b0;
      memReady   = 1'b0;
      memData    = 32'h0;
      test_reset();
      test_miss_fill();
      test_flush_idle();
      test_halfword();
      test_conflict();
      test_flush_fill();
      test_addr_change();
      test_reset_fetch();
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/instruction_cache.md
INSTRUCTION_CACHE -- requirements
Module: instruction_cache

Interface
REQ-001 Parameter: LINES, 16, number of one-word lines; power of two, at least 2.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  reset; asynchronous, active-high.
REQ-004 Port: cpuAddress  input  32  fetch address (program counter); halfword-aligned.
REQ-005 Port: cpuInstruction  output  32  fetched instruction, valid when cpuSuccess=1.
REQ-006 Port: cpuSuccess  output  1  hit indication; 0 means the core must stall.
REQ-007 Port: flush  input  1  invalidate all lines.
REQ-008 Port: memRequest  output  1  backing-memory read request.
REQ-009 Port: memAddress  output  32  word-aligned backing-memory read address.
REQ-010 Port: memReady  input  1  backing memory returns memData this cycle.
REQ-011 Port: memData  input  32  backing-memory read word.
REQ-012 Port: hitCount, missCount  output  32 each  statistics (present only under REQ-027).

Function
REQ-013 Index SHALL be cpuAddress[1+log2(LINES):2]; tag SHALL be cpuAddress[31:2+log2(LINES)].
REQ-014 Hit = state IDLE, valid[index]=1, stored tag equal; cpuSuccess SHALL be combinational, same cycle, zero latency.
REQ-015 cpuInstruction SHALL be the stored word when cpuAddress[1]=0, else {16'h0000, word[31:16]}; 32-bit instructions must be word-aligned.
REQ-016 cpuInstruction SHALL be 32'h0 whenever cpuSuccess=0.
REQ-017 FSM states IDLE and FETCH; IDLE->FETCH on miss with flush=0; FETCH->IDLE on memReady or flush.
REQ-018 On IDLE->FETCH, memAddress SHALL latch {cpuAddress[31:2],2'b00}; memRequest=1 from the next cycle.
REQ-019 memRequest and memAddress SHALL hold stable in FETCH until the memReady cycle; memRequest SHALL be 0 in IDLE.
REQ-020 On memReady in FETCH: write memData and tag at the latched index, set valid; hit possible the next cycle (miss latency = memory latency + 2 cycles).
REQ-021 cpuAddress changes during FETCH SHALL NOT abort the fill; lookup is re-evaluated in IDLE.
REQ-022 flush in IDLE SHALL clear all valid bits at the next edge; cpuSuccess SHALL be 0 in that flush cycle.
REQ-023 flush in FETCH (including the memReady cycle) SHALL discard the fill, leave valid bits cleared, return to IDLE.
REQ-024 Refill of an occupied line SHALL overwrite it (direct-mapped, no write path).

Reset
REQ-025 rst SHALL immediately force IDLE, all valid bits 0, memRequest 0, memAddress 0, counters 0; cpuSuccess thus 0.
REQ-026 rst during FETCH SHALL drop memRequest asynchronously; a memReady arriving after reset is ignored. Data/tag arrays are not reset.

Configuration
REQ-027 Macro ICACHE_STATS_EN defined: hitCount increments each cycle cpuSuccess=1; missCount increments on each IDLE->FETCH; both wrap modulo 2^32.
REQ-028 Macro undefined: hitCount/missCount ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-029 Shared package icache_pkg SHALL hold the state typedef (IDLE, FETCH), ADDR_WIDTH=32, default LINES.
REQ-030 Tag/data/valid storage SHALL be sub-module icache_line_store (one write port, one combinational read port, bulk valid clear).

Verification
REQ-031 Reset, cpuAddress=0x0 -> cpuSuccess=0; next cycle memRequest=1, memAddress=0x0.
REQ-032 Miss at 0x40, memReady 3 cycles later with memData=0x00500093 -> cpuSuccess=1, cpuInstruction=0x00500093 the cycle after memReady; missCount=1.
REQ-033 Cached 0x40 then fetch 0x42 (word 0x12344501) -> immediate hit, cpuInstruction=0x00001234.
REQ-034 LINES=16: fill 0x00 then 0x40 (same index) -> 0x00 misses again on re-fetch.
REQ-035 flush asserted together with memReady -> no valid line; re-fetch of same address misses.
REQ-036 rst pulse while memRequest=1 -> memRequest 0 without waiting for clk; later memReady has no effect; counters 0.
